prefetch_unit: RTL and testbench
================================

Name: prefetch_unit

Overview:
- Parametrised successor to the single-cycle fetch path: decouples PC generation from a memory with variable latency and backpressure.
- Issues in-order instruction requests, buffers up to DEPTH instructions with their PCs, presents them to decode over a valid/ready handshake.
- A redirect (branch/JAL/JALR target) flushes the buffer and discards in-flight responses.

Parameters:
- ADDRESS_BITS, 16: PC and instruction address width.
- DEPTH, 4: buffer entries; power of 2, minimum 2. Also the maximum number of outstanding plus buffered requests.
- RESET_PC, 0: PC fetched first after reset. Must be word aligned.

Ports:
- clock  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low; asserting (0) clears all state immediately.
- imem_req_valid  out  1  request valid.
- imem_req_ready  in  1  memory accepts the request this cycle.
- imem_req_addr  out  ADDRESS_BITS  word-aligned fetch address.
- imem_rsp_valid  in  1  response valid. Responses return in request order, latency at least 1 cycle.
- imem_rsp_data  in  32  instruction word.
- redirect_valid  in  1  flush and restart fetch.
- redirect_pc  in  ADDRESS_BITS  new fetch PC; bits [1:0] ignored (treated as 0).
- out_valid  out  1  buffered instruction available.
- out_ready  in  1  decode consumes the instruction.
- out_instr  out  32  instruction at head.
- out_pc  out  ADDRESS_BITS  PC of head instruction.

Behaviour:
- Reset values: imem_req_valid=0, imem_req_addr=RESET_PC, out_valid=0, out_instr=0, out_pc=0. All pointers, counters and drop count are 0.
- First request asserts in the first cycle after reset deasserts.
- Storage: DEPTH entries {pc, instr, filled}. Three pointers, each log2(DEPTH)+1 bits with a wrap bit:
  - alloc_ptr: entry reserved when a request handshake completes (valid&&ready); stores pc.
  - fill_ptr: advances on each non-dropped response; writes instr and sets filled.
  - rd_ptr: advances on out handshake.
- Request rule:
  - imem_req_valid = !(alloc_ptr-rd_ptr==DEPTH) && !redirect_valid.
  - imem_req_addr = fetch_pc.
  - On handshake, fetch_pc <= fetch_pc+4, modulo 2^ADDRESS_BITS (wraps to 0).
  - imem_req_valid, once high, holds with a stable address until accepted or redirected.
- Output rule:
  - out_valid = entry[rd_ptr].filled.
  - out_instr and out_pc are driven combinationally from the head entry.
  - Zero-latency bypass from response to output is not required. Minimum response-to-out_valid latency is 1 cycle.
- Full: no request issued. Responses always have a reserved entry, so no overflow is possible.
- Empty: out_valid=0. out_ready is ignored.
- Redirect (highest priority, single cycle):
  - rd_ptr, fill_ptr and alloc_ptr are set equal; all filled bits clear.
  - fetch_pc <= {redirect_pc[ADDRESS_BITS-1:2],2'b00}.
  - drop_cnt <= drop_cnt + (alloc_ptr-fill_ptr) − (response this cycle ? 1 : 0), counting requests still in flight.
  - No request is issued and no out handshake occurs in the redirect cycle. A request accepted that same cycle is impossible because valid is low.
  - A response arriving in the redirect cycle is discarded.
- Drop: while drop_cnt>0, each response decrements drop_cnt and is discarded. A new request may issue the cycle after redirect; its response is ordered after all dropped responses.
- Simultaneous request, response and out handshakes in one cycle are all legal and all take effect.
- Back-to-back redirects: the second redirect wins. drop_cnt accumulates correctly across both.
- Reset mid-operation: all state clears asynchronously. Responses to pre-reset requests are the memory's responsibility (the memory is reset too).

Optional Feature:
- Macro PREFETCH_STATS_EN. When defined, adds two output ports:
  - stat_fetched [31:0]: count of out handshakes.
  - stat_dropped [15:0]: count of discarded responses plus flushed filled entries; saturates at 0xFFFF.
  - Both clear on reset.
- When undefined: the ports and counters are absent, and behaviour is otherwise identical.

Decomposition:
- Shared package riscy_pkg:
  - INSTR_W=32, PC_STEP=4, NOP_INSTR=32'h00000013.
  - Pointer-width function clog2.
- Sub-module prefetch_buffer: DEPTH-entry reserve/fill/read ring holding {pc, instr, filled}, with the three pointers, full/count outputs and a flush input.
- prefetch_unit owns fetch_pc, drop_cnt, the request handshake and the stats counters.

Test Plan:
- Reset release, memory always ready, latency 1, out_ready=1 -> out_pc sequence 0x0000, 0x0004, 0x0008… with one instruction per cycle after a 2-cycle startup.
- out_ready=0, DEPTH=4, memory ready -> exactly 4 requests accepted (0x0,0x4,0x8,0xC), then imem_req_valid=0. Raising out_ready resumes a request at 0x10.
- Latency 3, 3 requests outstanding, redirect_pc=0x0102 -> next request address 0x0100. The 3 old responses are dropped. First out_pc=0x0100 with its matching instr. stat_dropped=3 when PREFETCH_STATS_EN is defined.
- imem_req_ready held 0 for 5 cycles -> imem_req_valid stays 1 and imem_req_addr stays stable. Accepted on the first ready cycle.
- fetch_pc=0xFFFC with ADDRESS_BITS=16 -> the following request address is 0x0000.
- Assert reset (0) asynchronously mid-burst with 2 entries filled -> out_valid=0 and imem_req_addr=RESET_PC immediately, without a clock edge.

Source files
------------

// File: rtl/riscy_pkg.sv
// Shared constants and helpers for the fetch front end.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package riscy_pkg;

  localparam int          INSTR_W   = 32;
  localparam int          PC_STEP   = 4;
  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  // Ceiling log2 for pointer sizing; clog2(1) == 0.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/prefetch_buffer.sv
// Reserve/fill/read ring of DEPTH {pc, instr, filled} entries.
// Latency: a fill is visible at the head one cycle after it is written.
// Backpressure: full blocks reservation upstream; rd_en only when head_vld.
// Ports: flush realigns all pointers to alloc_ptr; alloc_en/alloc_pc reserve an
//        entry, fill_en/fill_instr complete the oldest unfilled one, rd_en pops
//        the head; full/count/inflight/filled_cnt report occupancy.
module prefetch_buffer
  import riscy_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int ADDRESS_BITS = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    flush,
  input  logic                    alloc_en,
  input  logic [ADDRESS_BITS-1:0] alloc_pc,
  input  logic                    fill_en,
  input  logic [INSTR_W-1:0]      fill_instr,
  input  logic                    rd_en,
  output logic                    head_vld,
  output logic [ADDRESS_BITS-1:0] head_pc,
  output logic [INSTR_W-1:0]      head_instr,
  output logic                    full,
  output logic [clog2(DEPTH):0]   count,
  output logic [clog2(DEPTH):0]   inflight,
  output logic [clog2(DEPTH):0]   filled_cnt
);

  localparam int IW = clog2(DEPTH);
  localparam int PW = IW + 1;

  logic [PW-1:0]           alloc_ptr_q, alloc_ptr_d;
  logic [PW-1:0]           fill_ptr_q, fill_ptr_d;
  logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
  logic [ADDRESS_BITS-1:0] pc_q    [DEPTH];
  logic [ADDRESS_BITS-1:0] pc_d    [DEPTH];
  logic [INSTR_W-1:0]      instr_q [DEPTH];
  logic [INSTR_W-1:0]      instr_d [DEPTH];
  logic [DEPTH-1:0]        filled_q, filled_d;
  logic [IW-1:0]           alloc_idx, fill_idx, rd_idx;

  assign alloc_idx = alloc_ptr_q[IW-1:0];
  assign fill_idx  = fill_ptr_q[IW-1:0];
  assign rd_idx    = rd_ptr_q[IW-1:0];

  // Entries between rd and fill are the filled ones; between fill and alloc
  // are reserved slots waiting on their memory response.
  assign count      = alloc_ptr_q - rd_ptr_q;
  assign inflight   = alloc_ptr_q - fill_ptr_q;
  assign filled_cnt = fill_ptr_q - rd_ptr_q;
  assign full       = (count == PW'(DEPTH));

  assign head_vld   = filled_q[rd_idx];
  assign head_pc    = pc_q[rd_idx];
  assign head_instr = instr_q[rd_idx];

  // Index collisions cannot occur: alloc never targets the head unless the
  // ring is empty (head unfilled, so no read), and a fill targets an unfilled
  // slot that cannot be read in the same cycle.
  always_comb begin
    alloc_ptr_d = alloc_ptr_q;
    fill_ptr_d  = fill_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    pc_d        = pc_q;
    instr_d     = instr_q;
    filled_d    = filled_q;
    if (flush) begin
      fill_ptr_d = alloc_ptr_q;
      rd_ptr_d   = alloc_ptr_q;
      filled_d   = '0;
    end else begin
      if (alloc_en) begin
        pc_d[alloc_idx] = alloc_pc;
        alloc_ptr_d     = alloc_ptr_q + PW'(1);
      end
      if (fill_en) begin
        instr_d[fill_idx]  = fill_instr;
        filled_d[fill_idx] = 1'b1;
        fill_ptr_d         = fill_ptr_q + PW'(1);
      end
      if (rd_en) begin
        filled_d[rd_idx] = 1'b0;
        rd_ptr_d         = rd_ptr_q + PW'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      alloc_ptr_q <= '0;
      fill_ptr_q  <= '0;
      rd_ptr_q    <= '0;
      filled_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]    <= '0;
        instr_q[i] <= '0;
      end
    end else begin
      alloc_ptr_q <= alloc_ptr_d;
      fill_ptr_q  <= fill_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      filled_q    <= filled_d;
      pc_q        <= pc_d;
      instr_q     <= instr_d;
    end
  end

endmodule

// File: rtl/prefetch_unit.sv
// Instruction prefetcher: in-order fetch requests, DEPTH-entry buffer, decode handshake.
// Latency: response to out_valid is 1 cycle; first request in the first cycle after reset.
// Backpressure: requests stop when reserved+buffered entries reach DEPTH; out_ready stalls the head.
// Ports: imem_req_* fetch request, imem_rsp_* in-order responses, redirect_* flush and
//        restart, out_* head instruction and its PC. Defining PREFETCH_STATS_EN adds
//        stat_fetched (out handshakes) and stat_dropped (discarded work, saturating).
module prefetch_unit
  import riscy_pkg::*;
#(
  parameter int                      ADDRESS_BITS = 16,
  parameter int                      DEPTH        = 4,
  parameter logic [ADDRESS_BITS-1:0] RESET_PC     = '0
) (
  input  logic                    clock,
  input  logic                    reset,
  output logic                    imem_req_valid,
  input  logic                    imem_req_ready,
  output logic [ADDRESS_BITS-1:0] imem_req_addr,
  input  logic                    imem_rsp_valid,
  input  logic [INSTR_W-1:0]      imem_rsp_data,
  input  logic                    redirect_valid,
  input  logic [ADDRESS_BITS-1:0] redirect_pc,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [INSTR_W-1:0]      out_instr,
  output logic [ADDRESS_BITS-1:0] out_pc
`ifdef PREFETCH_STATS_EN
  ,
  output logic [31:0]             stat_fetched,
  output logic [15:0]             stat_dropped
`endif
);

  localparam int PW = clog2(DEPTH) + 1;

  logic [ADDRESS_BITS-1:0] fetch_pc_q, fetch_pc_d;
  logic [15:0]             drop_cnt_q, drop_cnt_d;
  logic                    buf_full;
  logic [PW-1:0]           buf_count, buf_inflight, buf_filled;
  logic                    dropping, req_fire, rsp_keep, out_fire;

  assign dropping = (drop_cnt_q != 16'd0);

  // Qualifying with reset holds the request low during reset while still
  // letting the first request out in the first cycle after release.
  assign imem_req_valid = reset && !buf_full && !redirect_valid;
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign rsp_keep       = imem_rsp_valid && !dropping && !redirect_valid;
  assign out_fire       = out_valid && out_ready && !redirect_valid;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    drop_cnt_d = drop_cnt_q;
    if (redirect_valid) begin
      fetch_pc_d = {redirect_pc[ADDRESS_BITS-1:2], 2'b00};
      // Every reserved-but-unfilled slot has a response still coming; one
      // arriving now is discarded immediately, so it is not counted again.
      drop_cnt_d = drop_cnt_q + 16'(buf_inflight) - 16'(imem_rsp_valid);
    end else begin
      if (req_fire) fetch_pc_d = fetch_pc_q + ADDRESS_BITS'(PC_STEP);
      if (imem_rsp_valid && dropping) drop_cnt_d = drop_cnt_q - 16'd1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fetch_pc_q <= RESET_PC;
      drop_cnt_q <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  prefetch_buffer #(
    .DEPTH        (DEPTH),
    .ADDRESS_BITS (ADDRESS_BITS)
  ) u_buf (
    .clock      (clock),
    .reset      (reset),
    .flush      (redirect_valid),
    .alloc_en   (req_fire),
    .alloc_pc   (fetch_pc_q),
    .fill_en    (rsp_keep),
    .fill_instr (imem_rsp_data),
    .rd_en      (out_fire),
    .head_vld   (out_valid),
    .head_pc    (out_pc),
    .head_instr (out_instr),
    .full       (buf_full),
    .count      (buf_count),
    .inflight   (buf_inflight),
    .filled_cnt (buf_filled)
  );

`ifdef PREFETCH_STATS_EN
  logic [31:0] stat_fetched_q, stat_fetched_d;
  logic [15:0] stat_dropped_q, stat_dropped_d;
  logic [16:0] dropped_sum;

  always_comb begin
    stat_fetched_d = stat_fetched_q + 32'(out_fire);
    // Discarded responses plus buffered instructions thrown away by a flush.
    dropped_sum = {1'b0, stat_dropped_q}
                + 17'(imem_rsp_valid && (redirect_valid || dropping))
                + (redirect_valid ? 17'(buf_filled) : 17'd0);
    stat_dropped_d = dropped_sum[16] ? 16'hFFFF : dropped_sum[15:0];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stat_fetched_q <= '0;
      stat_dropped_q <= '0;
    end else begin
      stat_fetched_q <= stat_fetched_d;
      stat_dropped_q <= stat_dropped_d;
    end
  end

  assign stat_fetched = stat_fetched_q;
  assign stat_dropped = stat_dropped_q;

  logic unused_occupancy;
  assign unused_occupancy = ^buf_count;
`else
  logic unused_occupancy;
  assign unused_occupancy = ^{buf_count, buf_filled};
`endif

endmodule

// File: tb/tb_prefetch_unit.sv
// Bench for prefetch_unit: in-order latency memory model, expected-PC queue
// scoreboard with a separate output monitor, directed scenarios, random phase.
module tb_prefetch_unit;

  localparam int          AW     = 16;
  localparam int          DEPTH  = 4;
  localparam logic [15:0] RST_PC = 16'h0000;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          imem_req_valid;
  logic          imem_req_ready = 1'b0;
  logic [AW-1:0] imem_req_addr;
  logic          imem_rsp_valid = 1'b0;
  logic [31:0]   imem_rsp_data  = 32'h0;
  logic          redirect_valid = 1'b0;
  logic [AW-1:0] redirect_pc    = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [31:0]   out_instr;
  logic [AW-1:0] out_pc;
`ifdef PREFETCH_STATS_EN
  logic [31:0]   stat_fetched;
  logic [15:0]   stat_dropped;
`endif

  always #5 clock = ~clock;

  prefetch_unit #(.ADDRESS_BITS(AW), .DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
    .clock          (clock),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc)
`ifdef PREFETCH_STATS_EN
    ,
    .stat_fetched   (stat_fetched),
    .stat_dropped   (stat_dropped)
`endif
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory contents are a fixed function of address.
  function automatic logic [31:0] instr_of(input logic [15:0] a);
    return {a ^ 16'hBEEF, ~a};
  endfunction

  // ---------------- reference model: expected decode stream ----------------
  logic [15:0] exp_q[$];
  logic [15:0] model_pc = RST_PC;
  int          n_req = 0;
  logic        hs_req = 1'b0;
  logic [15:0] hs_addr = '0;

  always @(negedge clock) begin
    if (!reset) begin
      exp_q.delete();
      model_pc = RST_PC;
      n_req    = 0;
      hs_req   = 1'b0;
    end else begin
      hs_req  = imem_req_valid && imem_req_ready;
      hs_addr = imem_req_addr;
      if (redirect_valid) begin
        check("req_in_redirect", {31'd0, imem_req_valid}, 32'd0);
        exp_q.delete();
        model_pc = redirect_pc & 16'hFFFC;
      end else if (hs_req) begin
        check("req_addr", {16'd0, hs_addr}, {16'd0, model_pc});
        exp_q.push_back(model_pc);
        model_pc = model_pc + 16'd4;
        n_req++;
      end
    end
  end

  // ---------------- monitor: pops and compares on each out handshake --------
  int          n_out = 0;
  logic [15:0] mon_e;

  always @(negedge clock) begin
    if (!reset) begin
      n_out = 0;
    end else if (!redirect_valid && out_valid && out_ready) begin
      n_out++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL out_unexpected: got pc %h with no expected entry", out_pc);
      end else begin
        mon_e = exp_q.pop_front();
        check("out_pc", {16'd0, out_pc}, {16'd0, mon_e});
        check("out_instr", out_instr, instr_of(mon_e));
      end
    end
  end

  // ---------------- memory: in-order, latency lat_min..lat_max -------------
  typedef struct {
    logic [15:0] addr;
    int          due;
  } mreq_t;
  mreq_t mem_q[$];
  int    cyc = 0;
  int    last_due = 0;
  int    lat_min = 1;
  int    lat_max = 1;

  always @(posedge clock) begin
    cyc++;
    #1;
    imem_rsp_valid = 1'b0;
    if (!reset) begin
      mem_q.delete();
      last_due = 0;
    end else begin
      if (hs_req) begin
        int due;
        due = cyc + int'($urandom_range(lat_max, lat_min)) - 1;
        if (due <= last_due) due = last_due + 1;
        mem_q.push_back('{hs_addr, due});
        last_due = due;
        hs_req = 1'b0;
      end
      if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = instr_of(mem_q[0].addr);
        void'(mem_q.pop_front());
      end
    end
  end

  // ---------------- stimulus ----------------
  logic rand_en = 1'b0;

  task automatic step();
    @(posedge clock);
    #1;
    if (rand_en) begin
      imem_req_ready = ($urandom_range(99, 0) < 70);
      out_ready      = ($urandom_range(99, 0) < 70);
      redirect_valid = ($urandom_range(99, 0) < 3);
      redirect_pc    = 16'($urandom);
    end
  endtask

  task automatic do_reset();
    reset          = 1'b0;
    imem_req_ready = 1'b0;
    out_ready      = 1'b0;
    redirect_valid = 1'b0;
    repeat (2) step();
    reset = 1'b1;
  endtask

  // Waits at negedges for a request handshake; expiry counts as a failure.
  task automatic wait_req(input string name, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (imem_req_valid && imem_req_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: no request handshake within 20 cycles", name);
    end
  endtask

  initial begin
    bit ok;

    // Reset values while reset is held.
    #2;
    check("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    check("rst_req_addr", {16'd0, imem_req_addr}, {16'd0, RST_PC});
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_instr", out_instr, 32'd0);
    check("rst_out_pc", {16'd0, out_pc}, 32'd0);

    // Streaming: latency 1, always ready; one instruction per cycle.
    lat_min = 1; lat_max = 1;
    do_reset();
    imem_req_ready = 1'b1;
    out_ready      = 1'b1;
    @(negedge clock);
    check("first_req_valid", {31'd0, imem_req_valid}, 32'd1);
    step(); step();
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      check("stream_valid", {31'd0, out_valid}, 32'd1);
      step();
    end

    // Full: decode stalled, exactly DEPTH requests then stop.
    do_reset();
    imem_req_ready = 1'b1;
    repeat (10) step();
    @(negedge clock);
    check("full_req_count", n_req, DEPTH);
    check("full_req_valid", {31'd0, imem_req_valid}, 32'd0);
    step();
    out_ready = 1'b1;
    wait_req("resume_req", ok);
    if (ok) check("resume_addr", {16'd0, imem_req_addr}, 32'h0010);

    // Redirect with three requests outstanding at latency 3.
    lat_min = 3; lat_max = 3;
    do_reset();
    imem_req_ready = 1'b1;
    out_ready      = 1'b1;
    repeat (3) step();
    redirect_valid = 1'b1;
    redirect_pc    = 16'h0102;
    step();
    redirect_valid = 1'b0;
    wait_req("redirect_req", ok);
    if (ok) check("redirect_addr", {16'd0, imem_req_addr}, 32'h0100);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_cmp++;
      n_err++;
      $display("FAIL redirect_out: no output within 20 cycles");
    end else begin
      check("redirect_out_pc", {16'd0, out_pc}, 32'h0100);
      check("redirect_out_instr", out_instr, instr_of(16'h0100));
    end
    repeat (10) step();
`ifdef PREFETCH_STATS_EN
    check("stat_dropped", {16'd0, stat_dropped}, 32'd3);
`endif

    // Memory stalls: request holds with a stable address.
    imem_req_ready = 1'b0;
    repeat (4) step();
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check("hold_valid", {31'd0, imem_req_valid}, 32'd1);
      check("hold_addr", {16'd0, imem_req_addr}, {16'd0, model_pc});
      step();
    end
    imem_req_ready = 1'b1;
    @(negedge clock);
    check("hold_accept", {31'd0, imem_req_valid && imem_req_ready}, 32'd1);

    // Address wrap at the top of the PC space.
    lat_min = 1; lat_max = 1;
    step();
    redirect_valid = 1'b1;
    redirect_pc    = 16'hFFFD;
    step();
    redirect_valid = 1'b0;
    wait_req("wrap_req", ok);
    if (ok) begin
      check("wrap_top_addr", {16'd0, imem_req_addr}, 32'h0000FFFC);
      step();
      @(negedge clock);
      check("wrap_next_valid", {31'd0, imem_req_valid}, 32'd1);
      check("wrap_next_addr", {16'd0, imem_req_addr}, 32'h0000);
    end

    // Asynchronous reset with two filled entries.
    do_reset();
    imem_req_ready = 1'b1;
    step(); step();
    imem_req_ready = 1'b0;
    step(); step();
    @(negedge clock);
    check("pre_reset_valid", {31'd0, out_valid}, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("async_out_valid", {31'd0, out_valid}, 32'd0);
    check("async_req_addr", {16'd0, imem_req_addr}, {16'd0, RST_PC});
    check("async_req_valid", {31'd0, imem_req_valid}, 32'd0);

    // Random traffic: ready, stalls, redirects, latency 1..4.
    lat_min = 1; lat_max = 4;
    do_reset();
    rand_en = 1'b1;
    repeat (3000) step();
    rand_en        = 1'b0;
    redirect_valid = 1'b0;
    imem_req_ready = 1'b1;
    out_ready      = 1'b1;
    repeat (40) step();
`ifdef PREFETCH_STATS_EN
    check("stat_fetched", stat_fetched, n_out);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
